// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding req/ack fetch from instruction
// memory, a one-entry skid for words that arrive while decode is stalled,
// and the IF/ID pipeline register. Redirects kill in-flight fetches and
// flush IF/ID.
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC_IF,
  input  logic              j_br,
  output logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall_ID,
  output logic              valid_ID,
  output logic [DATA_W-1:0] instr_ID,
  output logic [ADDR_W-1:0] PC_ID
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                kill_q, kill_d;
  logic [DATA_W-1:0]   skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;

  logic                out_free;
  logic                commit;
  logic [DATA_W-1:0]   ld_instr;
  logic [ADDR_W-1:0]   ld_pc;

  assign out_free = !valid_q || !stall_ID;

  // Fetch FSM: next state, memory request outputs and the commit decision.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    kill_d       = kill_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    imem_req     = 1'b0;
    imem_addr    = '0;
    commit       = 1'b0;
    ld_instr     = skid_instr_q;
    ld_pc        = skid_pc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        imem_req   = 1'b1;
        imem_addr  = PC_IF;
        req_addr_d = PC_IF;
        if (imem_ack) begin
          // An ack coinciding with a redirect is simply dropped; the PC
          // already points at the target, so REQ re-issues from there.
          if (!j_br) begin
            if (out_free) begin
              commit   = 1'b1;
              ld_instr = imem_rdata;
              ld_pc    = PC_IF;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = PC_IF;
              state_d      = HOLD;
            end
          end
        end else begin
          kill_d  = j_br;
          state_d = WAIT;
        end
      end
      WAIT: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        if (!imem_ack) begin
          kill_d = kill_q || j_br;
        end else if (kill_q || j_br) begin
          kill_d  = 1'b0;
          state_d = REQ;
        end else if (out_free) begin
          commit   = 1'b1;
          ld_instr = imem_rdata;
          ld_pc    = req_addr_q;
          state_d  = REQ;
        end else begin
          skid_instr_d = imem_rdata;
          skid_pc_d    = req_addr_q;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (j_br) begin
          state_d = REQ;
        end else if (out_free) begin
          commit  = 1'b1;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    stall = !commit;
  end

  // IF/ID register: flush on redirect, hold on decode stall, else take commit.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (j_br) begin
      valid_d = 1'b0;
    end else if (stall_ID && valid_q) begin
      valid_d = 1'b1;
    end else if (commit) begin
      valid_d = 1'b1;
      instr_d = ld_instr;
      pc_d    = ld_pc;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State and register update; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      kill_q       <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc_q         <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      kill_q       <= kill_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
    end
  end

  assign valid_ID = valid_q;
  assign instr_ID = instr_q;
  assign PC_ID    = pc_q;

endmodule
